// File: rtl/mem_resp_stage_if.sv
// rtl/mem_resp_stage_if.sv - EX/RAM/WB signal bundle for the MEM response stage
interface mem_resp_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [4:0]        es_load_op;
    logic              es_mem_req;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [DATA_W-1:0] es_result;
    logic [PC_W-1:0]   es_pc;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [DATA_W-1:0] ms_result;
    logic [PC_W-1:0]   ms_pc;
    logic              fwd_valid;
    logic              fwd_block;
    logic              flush;
    logic              ms_ale;

    // Environment side: EX payload, RAM response, WB backpressure, flush
    modport master (
        output es_to_ms_valid, es_load_op, es_mem_req, es_gr_we, es_dest,
               es_result, es_pc, data_ok, rdata, ws_allowin, flush,
        input  ms_allowin, ms_to_ws_valid, ms_gr_we, ms_dest, ms_result,
               ms_pc, fwd_valid, fwd_block, ms_ale
    );

    // Stage side
    modport slave (
        input  es_to_ms_valid, es_load_op, es_mem_req, es_gr_we, es_dest,
               es_result, es_pc, data_ok, rdata, ws_allowin, flush,
        output ms_allowin, ms_to_ws_valid, ms_gr_we, ms_dest, ms_result,
               ms_pc, fwd_valid, fwd_block, ms_ale
    );
endinterface

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM stage: awaits RAM response, buffers, extracts load data; optional MS_ALE_CHECK_EN
module mem_resp_stage #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             resetn,
    mem_resp_stage_if.slave  bus
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int DCNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_OUTST);

    logic              r_ms_valid;
    logic              r_buf_valid;
    logic              r_got;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DATA_W-1:0] r_buf;
    logic [4:0]        r_load_op;
    logic              r_gr_we;
    logic [4:0]        r_dest;
    logic [DATA_W-1:0] r_result;
    logic [PC_W-1:0]   r_pc;

    logic              w_dcnt_zero;
    logic              w_ready_go;
    logic              w_to_ws;
    logic              w_allowin;
    logic              w_accept;
    logic              w_leave;
    logic              w_take;
    logic              w_drop;
    logic              w_kill_wait;
    logic [DATA_W-1:0] w_data;
    logic [OFF_W-1:0]  w_sel;
    logic [OFF_W-1:0]  w_half_off;
    logic [OFF_W-1:0]  w_word_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_word;
    logic [DATA_W-1:0] w_ext;
    logic              w_is_load;
    logic              w_ale;

    // A response while dcnt is nonzero always belongs to a killed instruction
    assign w_dcnt_zero = (r_dcnt == '0);
    assign w_ready_go  = r_got | (bus.data_ok & w_dcnt_zero);
    assign w_to_ws     = r_ms_valid & w_ready_go & ~bus.flush;
    assign w_allowin   = (~r_ms_valid | (w_ready_go & bus.ws_allowin))
                       & (r_dcnt != DCNT_MAX) & ~bus.flush;
    assign w_accept    = bus.es_to_ms_valid & w_allowin;
    assign w_leave     = w_to_ws & bus.ws_allowin;
    assign w_take      = bus.data_ok & w_dcnt_zero & r_ms_valid & ~r_got;
    assign w_drop      = bus.data_ok & ~w_dcnt_zero;
    // Killing a waiting instruction leaves its response in flight, unless it lands this very cycle
    assign w_kill_wait = bus.flush & r_ms_valid & ~r_got & ~(bus.data_ok & w_dcnt_zero);

    // Stage occupancy, response tracking and read-data hold buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
            r_got       <= 1'b0;
            r_dcnt      <= '0;
            r_buf       <= '0;
        end else begin
            r_dcnt <= r_dcnt + DCNT_W'(w_kill_wait) - DCNT_W'(w_drop);
            if (bus.flush) begin
                r_ms_valid  <= 1'b0;
                r_buf_valid <= 1'b0;
            end else if (w_accept) begin
                r_ms_valid  <= 1'b1;
                r_buf_valid <= 1'b0;
                r_got       <= ~bus.es_mem_req;
            end else if (w_leave) begin
                r_ms_valid  <= 1'b0;
                r_buf_valid <= 1'b0;
            end else if (w_take) begin
                r_got       <= 1'b1;
                r_buf_valid <= 1'b1;
                r_buf       <= bus.rdata;
            end
        end
    end

    // Instruction payload captured on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_load_op <= '0;
            r_gr_we   <= 1'b0;
            r_dest    <= '0;
            r_result  <= '0;
            r_pc      <= '0;
        end else if (w_accept) begin
            r_load_op <= bus.es_load_op;
            r_gr_we   <= bus.es_gr_we;
            r_dest    <= bus.es_dest;
            r_result  <= bus.es_result;
            r_pc      <= bus.es_pc;
        end
    end

    // Lane select: buffered data once held, otherwise the live response is bypassed
    assign w_data     = r_buf_valid ? r_buf : bus.rdata;
    assign w_sel      = r_result[OFF_W-1:0];
    assign w_half_off = w_sel & ~OFF_W'(1);
    assign w_word_off = w_sel & ~OFF_W'(3);
    assign w_byte     = 8'(w_data >> {w_sel, 3'b000});
    assign w_half     = 16'(w_data >> {w_half_off, 3'b000});
    assign w_word     = 32'(w_data >> {w_word_off, 3'b000});
    assign w_is_load  = |r_load_op;

    // Sign or zero extension according to the one-hot load kind
    always_comb begin
        w_ext = '0;
        if (r_load_op[0]) w_ext = DATA_W'($signed(w_byte));
        if (r_load_op[1]) w_ext = DATA_W'($signed(w_half));
        if (r_load_op[2]) w_ext = DATA_W'($signed(w_word));
        if (r_load_op[3]) w_ext = DATA_W'(w_byte);
        if (r_load_op[4]) w_ext = DATA_W'(w_half);
    end

`ifdef MS_ALE_CHECK_EN
    // Misaligned load: suppress the GPR write and hand the vaddr to WB as BADV
    assign w_ale         = r_ms_valid & (((r_load_op[1] | r_load_op[4]) & w_sel[0])
                                       | (r_load_op[2] & (w_sel[1:0] != 2'b00)));
    assign bus.ms_gr_we  = r_gr_we & ~w_ale;
    assign bus.ms_result = (w_is_load & ~w_ale) ? w_ext : r_result;
`else
    assign w_ale         = 1'b0;
    assign bus.ms_gr_we  = r_gr_we;
    assign bus.ms_result = w_is_load ? w_ext : r_result;
`endif

    assign bus.ms_ale         = w_ale;
    assign bus.ms_allowin     = w_allowin;
    assign bus.ms_to_ws_valid = w_to_ws;
    assign bus.ms_dest        = r_dest;
    assign bus.ms_pc          = r_pc;
    assign bus.fwd_valid      = r_ms_valid & bus.ms_gr_we;
    assign bus.fwd_block      = bus.fwd_valid & w_is_load & ~r_got;
endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - self-checking bench for mem_resp_stage
module tb_mem_resp_stage;
    localparam int DW   = 32;
    localparam int PW   = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_resp_stage_if #(.DATA_W(DW), .PC_W(PW)) u_if ();
    mem_resp_stage #(.DATA_W(DW), .PC_W(PW), .MAX_OUTST(MAXO)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one instruction slot plus an in-order queue of outstanding
    // RAM requests, each tagged with whether its instruction was killed.
    bit          m_v, m_done;
    logic [4:0]  m_lop;
    bit          m_gwe;
    logic [4:0]  m_dest;
    logic [31:0] m_res, m_pc, m_data;
    bit          m_q[$];

    logic        o_allow, o_tows, o_fblk, o_gwe, o_ale;
    logic [31:0] o_res;

    function automatic logic [31:0] ld_ext(input logic [4:0] lop, input logic [31:0] addr,
                                           input logic [31:0] d);
        int sel;
        logic [31:0] b, h;
        sel = int'(addr[1:0]);
        b = (d >> (8 * sel)) & 32'hFF;
        h = (d >> (16 * (sel / 2))) & 32'hFFFF;
        case (lop)
            5'b00001: return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            5'b00010: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            5'b00100: return d;
            5'b01000: return b;
            5'b10000: return h;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int n_killed();
        int n = 0;
        foreach (m_q[i]) if (m_q[i]) n++;
        return n;
    endfunction

    function automatic bit ale_of(input logic [4:0] lop, input logic [31:0] addr);
        bit a = 1'b0;
`ifdef MS_ALE_CHECK_EN
        a = ((lop == 5'b00010 || lop == 5'b10000) && addr[0])
         || (lop == 5'b00100 && addr[1:0] != 2'b00);
`endif
        return a;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance the model at posedge
    task automatic step(input bit v, input logic [4:0] lop, input bit req, input bit gwe,
                        input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc,
                        input bit dok, input logic [31:0] rd, input bit wsa, input bit fl);
        bit rdy, tows, allow, mine, ale, k;
        logic [31:0] d, exp_res;
        bit exp_gwe;
        if (m_q.size() == 0) dok = 1'b0;
        u_if.es_to_ms_valid = v;   u_if.es_load_op = lop; u_if.es_mem_req = req;
        u_if.es_gr_we = gwe;       u_if.es_dest = dest;   u_if.es_result = res;
        u_if.es_pc = pc;           u_if.data_ok = dok;    u_if.rdata = rd;
        u_if.ws_allowin = wsa;     u_if.flush = fl;
        @(negedge clk);
        mine    = dok && !m_q[0];
        rdy     = m_done || mine;
        tows    = m_v && rdy && !fl;
        allow   = (!m_v || (rdy && wsa)) && (n_killed() < MAXO) && !fl;
        d       = m_done ? m_data : rd;
        ale     = m_v && ale_of(m_lop, m_res);
        exp_res = ((m_lop != 0) && !ale) ? ld_ext(m_lop, m_res, d) : m_res;
        exp_gwe = m_gwe && !ale;
        o_allow = u_if.ms_allowin;  o_tows = u_if.ms_to_ws_valid; o_fblk = u_if.fwd_block;
        o_gwe   = u_if.ms_gr_we;    o_ale  = u_if.ms_ale;         o_res  = u_if.ms_result;
        chk("allowin", o_allow, allow);
        chk("to_ws_valid", o_tows, tows);
        chk("fwd_valid", u_if.fwd_valid, m_v && exp_gwe);
        chk("fwd_block", o_fblk, m_v && exp_gwe && (m_lop != 0) && !m_done);
        chk("ms_ale", o_ale, ale);
        if (tows) begin
            chk("ms_result", o_res, exp_res);
            chk("ms_gr_we", o_gwe, exp_gwe);
            chk("ms_dest", u_if.ms_dest, m_dest);
            chk("ms_pc", u_if.ms_pc, m_pc);
        end
        @(posedge clk);
        if (dok) begin
            k = m_q.pop_front();
            if (!k) begin m_done = 1'b1; m_data = rd; end
        end
        if (fl) begin
            if (m_v && !m_done) m_q[m_q.size()-1] = 1'b1;
            m_v = 1'b0;
        end else begin
            if (tows && wsa) m_v = 1'b0;
            if (v && allow) begin
                m_v = 1'b1; m_done = !req; m_lop = lop; m_gwe = gwe;
                m_dest = dest; m_res = res; m_pc = pc;
                if (req) m_q.push_back(1'b0);
            end
        end
        #1;
    endtask

    task automatic idle(input bit dok, input logic [31:0] rd, input bit wsa);
        step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, dok, rd, wsa, 1'b0);
    endtask

    task automatic issue(input logic [4:0] lop, input logic [31:0] addr);
        step(1'b1, lop, 1'b1, 1'b1, 5'd7, addr, 32'h1C00_0000 + addr, 1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_allowin"}, u_if.ms_allowin, 1'b1);
        chk({tag, "_to_ws"}, u_if.ms_to_ws_valid, 1'b0);
        chk({tag, "_result"}, u_if.ms_result, 32'h0);
        chk({tag, "_gr_we"}, u_if.ms_gr_we, 1'b0);
        chk({tag, "_fwd_valid"}, u_if.fwd_valid, 1'b0);
        chk({tag, "_pc"}, u_if.ms_pc, 32'h0);
    endtask

    initial begin
        logic [4:0] lop;
        int lsel;
        bit req, gwe;
        u_if.es_to_ms_valid = 0; u_if.es_load_op = 0; u_if.es_mem_req = 0; u_if.es_gr_we = 0;
        u_if.es_dest = 0; u_if.es_result = 0; u_if.es_pc = 0; u_if.data_ok = 0;
        u_if.rdata = 0; u_if.ws_allowin = 0; u_if.flush = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // lw, response in first MEM cycle, single beat
        issue(5'b00100, 32'h1004);
        idle(1'b1, 32'h8000_00FF, 1'b1);
        chk("t1_result", o_res, 32'h8000_00FF);
        chk("t1_beat", o_tows, 1'b1);
        idle(1'b0, 32'd0, 1'b1);
        chk("t1_no_second_beat", o_tows, 1'b0);

        // lb sign extension with a three-cycle wait
        issue(5'b00001, 32'h1003);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 32'd0, 1'b1);
            chk("t2_fwd_block", o_fblk, 1'b1);
        end
        idle(1'b1, 32'h8012_3456, 1'b1);
        chk("t2_result", o_res, 32'hFFFF_FF80);

        // lhu held across a WB stall
        issue(5'b10000, 32'h2);
        idle(1'b1, 32'h8012_3456, 1'b0);
        chk("t3_result_dok", o_res, 32'h0000_8012);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 32'h0BAD_0BAD, 1'b0);
            chk("t3_result_hold", o_res, 32'h0000_8012);
            chk("t3_fwd_block_low", o_fblk, 1'b0);
        end
        idle(1'b0, 32'h0BAD_0BAD, 1'b1);
        chk("t3_result_go", o_res, 32'h0000_8012);
        idle(1'b0, 32'd0, 1'b1);
        chk("t3_single_beat", o_tows, 1'b0);

        // flushed load: its response is dropped, the next load gets the second one
        issue(5'b00100, 32'h2000);
        step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        issue(5'b00100, 32'h3000);
        chk("t4_accept_after_flush", o_allow, 1'b1);
        idle(1'b1, 32'hDEAD_0000, 1'b1);
        chk("t4_stale_dropped", o_tows, 1'b0);
        idle(1'b1, 32'h1234_5678, 1'b1);
        chk("t4_result", o_res, 32'h1234_5678);

        // two killed responses outstanding blocks acceptance until one drains
        issue(5'b00100, 32'h4000);
        step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        issue(5'b00100, 32'h4004);
        step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        issue(5'b00100, 32'h4008);
        chk("t5_allowin_full", o_allow, 1'b0);
        idle(1'b1, 32'h1111_1111, 1'b1);
        chk("t5_allowin_drain_cycle", o_allow, 1'b0);
        idle(1'b0, 32'd0, 1'b1);
        chk("t5_allowin_reopened", o_allow, 1'b1);
        idle(1'b1, 32'h2222_2222, 1'b1);

`ifdef MS_ALE_CHECK_EN
        issue(5'b00100, 32'h1002);
        idle(1'b1, 32'hCAFE_F00D, 1'b1);
        chk("t7_ale", o_ale, 1'b1);
        chk("t7_gr_we", o_gwe, 1'b0);
        chk("t7_badv", o_res, 32'h1002);
`endif

        // asynchronous reset while a load waits
        issue(5'b00100, 32'h5000);
        idle(1'b0, 32'd0, 1'b1);
        resetn = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        m_v = 1'b0; m_done = 1'b0; m_q.delete();
        resetn = 1'b1;
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lsel = $urandom_range(0, 7);
            lop  = (lsel < 5) ? 5'(1 << lsel) : 5'd0;
            req  = (lop != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            gwe  = (lop != 0) ? 1'b1 : (req ? 1'b0 : 1'($urandom_range(0, 1)));
            step($urandom_range(0, 9) < 7, lop, req, gwe, 5'($urandom), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
